muldiv_sched: RTL and testbench
===============================

// Module: muldiv_sched
// PURPOSE
//  Multi-cycle HI/LO arithmetic scheduler for the EX stage. Accepts mult/multu/div/divu from EX.
//  Sequences an internal MUL_LAT-stage multiplier and a 32-iteration restoring divider.
//  Holds the pipeline via stallreq until the result is ready, then presents the HI/LO write to EX.
//  EX forwards that write down the pipeline alongside the instruction.
// PARAMETERS
//  MUL_LAT  2  multiplier pipeline depth in cycles (>=1)
// PORTS
//  clk           in   1   clock; all state updates on posedge
//  rst           in   1   synchronous, active-high reset
//  op_valid      in   1   EX holds a valid instruction this cycle
//  op_code       in   3   000 none, 001 mult, 010 multu, 011 div, 100 divu; others treated as none
//  src_a         in   32  rs operand (dividend / multiplicand)
//  src_b         in   32  rt operand (divisor / multiplier)
//  stall_ex      in   1   EX held by a downstream stall source; result must persist
//  annul         in   1   flush: abandon current operation
//  stallreq      out  1   request pipeline stall (combinational from state and inputs)
//  busy          out  1   state != IDLE
//  hilo_we       out  1   HI and LO write enable (both written together)
//  hi_wdata      out  32  HI result: product[63:32] or remainder
//  lo_wdata      out  32  LO result: product[31:0] or quotient
//  div_by_zero   out  1   divisor was zero; valid while hilo_we=1
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, all outputs 0, operand/result registers 0.
//  Reset has priority over every other input.
//  States: IDLE, MUL, DIV, DONE.
//  IDLE:
//   - Trigger: op_valid & legal op_code & !annul.
//   - On trigger, latch src_a/src_b and op_code; stallreq=1 in this same cycle.
//   - mult/multu -> MUL, counter=1.
//   - div/divu with src_b!=0 -> DIV, counter=1.
//   - div/divu with src_b==0 -> DONE.
//   - No trigger: stallreq=0, hilo_we=0.
//  MUL:
//   - stallreq=1.
//   - Latched operands go through the MUL_LAT-stage product pipe (signed for mult, unsigned for multu).
//   - Leave for DONE when counter==MUL_LAT; otherwise counter++.
//  DIV:
//   - stallreq=1.
//   - Signed (div): divide operand magnitudes; quotient negated if a[31]^b[31]; remainder takes sign of a.
//   - One quotient bit per cycle: 33-bit trial subtract of the partial remainder.
//   - Leave for DONE when counter==32 (32 iterations).
//  DONE:
//   - stallreq=0, hilo_we=1.
//   - hi/lo_wdata and div_by_zero are stable registered values.
//   - stall_ex=1: stay in DONE with outputs held; repeated identical writes are legal.
//   - stall_ex=0: go to IDLE; hilo_we=0 next cycle.
//   - A new op is accepted only from IDLE, never from DONE.
//  Latency (accept cycle = cycle 0):
//   - mul: DONE at cycle MUL_LAT+1; stallreq high MUL_LAT+1 cycles.
//   - div: DONE at cycle 33; stallreq high 33 cycles.
//   - div-by-zero: DONE at cycle 1.
//  Divide by zero: hi_wdata=src_a, lo_wdata=32'hFFFF_FFFF, div_by_zero=1.
//  Signed overflow: 0x8000_0000 / 0xFFFF_FFFF gives lo=0x8000_0000, hi=0 (wraps, no flag).
//  annul:
//   - In any state, annul=1 forces stallreq=0 and hilo_we=0 combinationally.
//   - State -> IDLE next cycle; no write is issued.
//   - annul in IDLE with op_valid: op not accepted.
//  Inputs are sampled only in IDLE; EX may change them while the block is busy.
//  Illegal op_code while busy is ignored.
// TESTING
//  1 multu a=FFFFFFFF b=FFFFFFFF -> hi=FFFFFFFE lo=00000001; stallreq high exactly 3 cycles (MUL_LAT=2).
//  2 mult a=FFFFFFFE(-2) b=00000003 -> hi=FFFFFFFF lo=FFFFFFFA; div a=FFFFFFF9(-7) b=2 -> lo=FFFFFFFD hi=FFFFFFFF; stallreq 33 cycles.
//  3 divu a=100 b=0 -> DONE at cycle 1: div_by_zero=1, hi=00000064, lo=FFFFFFFF; div a=80000000 b=FFFFFFFF -> lo=80000000 hi=0.
//  4 annul asserted at cycle 10 of a div -> stallreq=0 that cycle; busy=0 next cycle; no hilo_we; a following divu 9/4 -> lo=2 hi=1.
//  5 stall_ex=1 for 2 cycles on reaching DONE -> hilo_we high 3 cycles, data unchanged; then IDLE, hilo_we=0.
//  6 rst asserted mid-div -> next cycle all outputs 0, busy=0; a mult issued immediately after gives the correct result.

Source files
------------

// File: rtl/muldiv_sched_if.sv
// ---------------------------------------------------------------------------
// muldiv_sched_if
// Handshake and data bundle between the EX stage (master) and the HI/LO
// multiply/divide scheduler (slave).
//   op_valid/op_code/src_a/src_b : instruction issued by EX
//   stall_ex                     : EX is held downstream; result must persist
//   annul                        : flush, abandon the current operation
//   stallreq/busy                : scheduler status back to EX
//   hilo_we/hi_wdata/lo_wdata    : HI/LO write presented to EX
//   div_by_zero                  : divisor was zero (valid with hilo_we)
// ---------------------------------------------------------------------------
interface muldiv_sched_if;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        stall_ex;
  logic        annul;
  logic        stallreq;
  logic        busy;
  logic        hilo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;
  logic        div_by_zero;

  modport master (
    output op_valid, op_code, src_a, src_b, stall_ex, annul,
    input  stallreq, busy, hilo_we, hi_wdata, lo_wdata, div_by_zero
  );

  modport slave (
    input  op_valid, op_code, src_a, src_b, stall_ex, annul,
    output stallreq, busy, hilo_we, hi_wdata, lo_wdata, div_by_zero
  );
endinterface

// File: rtl/muldiv_sched.sv
// ---------------------------------------------------------------------------
// muldiv_sched
// Multi-cycle HI/LO arithmetic scheduler for the EX stage. Runs mult/multu
// through a MUL_LAT-stage product pipe and div/divu through a 32-iteration
// restoring divider, stalling the pipeline until the HI/LO write is ready.
// Ports:
//   clk  : clock, all state updates on posedge
//   rst  : synchronous active-high reset, highest priority
//   bus  : muldiv_sched_if.slave (operation in, stall/status/result out)
// ---------------------------------------------------------------------------
module muldiv_sched #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  muldiv_sched_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam int unsigned PIPE_N  = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;

  state_e      r_state;
  logic [5:0]  r_count;
  logic [31:0] r_a;        // multiplicand, or dividend magnitude shifting into quotient
  logic [31:0] r_b;        // multiplier, or divisor magnitude
  logic [31:0] r_rem;      // divider partial remainder
  logic        r_signed;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_dbz;
  logic [63:0] r_pipe [PIPE_N];

  // ---- issue decode (only meaningful in IDLE) ----
  logic        w_legal, w_trigger, w_is_mul, w_is_signed;
  logic [31:0] w_abs_a, w_abs_b;

  assign w_legal     = bus.op_code inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  assign w_trigger   = bus.op_valid & w_legal & ~bus.annul;
  assign w_is_mul    = (bus.op_code == OP_MULT) | (bus.op_code == OP_MULTU);
  assign w_is_signed = (bus.op_code == OP_MULT) | (bus.op_code == OP_DIV);
  // 0x8000_0000 negates to itself, which is the correct unsigned magnitude.
  assign w_abs_a     = (w_is_signed & bus.src_a[31]) ? -bus.src_a : bus.src_a;
  assign w_abs_b     = (w_is_signed & bus.src_b[31]) ? -bus.src_b : bus.src_b;

  // ---- multiplier: extend to 64 bits so one unsigned multiply serves both ----
  logic [63:0] w_mul_a, w_mul_b, w_prod;
  logic [63:0] w_stage [MUL_LAT];

  assign w_mul_a = r_signed ? {{32{r_a[31]}}, r_a} : {32'b0, r_a};
  assign w_mul_b = r_signed ? {{32{r_b[31]}}, r_b} : {32'b0, r_b};
  assign w_prod  = w_mul_a * w_mul_b;

  // w_stage[k] is the product after k registers; the final register is r_hi/r_lo.
  // NOTE: every variable assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    w_stage[0] = w_prod;
    for (int i = 1; i < MUL_LAT; i++) w_stage[i] = r_pipe[i-1];
  end

  // NOTE: the product pipe is reset along with the other operand/result state
  // so nothing in the block powers up as X.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_N; i++) r_pipe[i] <= '0;
    end else begin
      for (int i = 0; i < PIPE_N; i++) r_pipe[i] <= w_stage[i];
    end
  end

  // ---- divider: one restoring step per cycle ----
  logic [32:0] w_shift;    // partial remainder with next dividend bit shifted in
  logic [33:0] w_diff;     // trial subtract, bit 33 is the borrow
  logic        w_fits;
  logic [31:0] w_rem_next, w_q_next;

  assign w_shift    = {r_rem, r_a[31]};
  assign w_diff     = {1'b0, w_shift} - {2'b0, r_b};
  assign w_fits     = ~w_diff[33];
  assign w_rem_next = w_fits ? w_diff[31:0] : w_shift[31:0];
  assign w_q_next   = {r_a[30:0], w_fits};

  // ---- control FSM ----
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_signed <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_dbz    <= 1'b0;
    end else if (bus.annul) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_a      <= w_is_mul ? bus.src_a : w_abs_a;
            r_b      <= w_is_mul ? bus.src_b : w_abs_b;
            r_signed <= w_is_signed;
            r_neg_q  <= w_is_signed & (bus.src_a[31] ^ bus.src_b[31]);
            r_neg_r  <= w_is_signed & bus.src_a[31];
            r_rem    <= '0;
            r_dbz    <= 1'b0;
            if (w_is_mul) begin
              r_state <= S_MUL;
              r_count <= 6'd1;
            end else if (bus.src_b == '0) begin
              r_state <= S_DONE;
              r_hi    <= bus.src_a;
              r_lo    <= 32'hFFFF_FFFF;
              r_dbz   <= 1'b1;
            end else begin
              r_state <= S_DIV;
              r_count <= 6'd1;
            end
          end
        end
        S_MUL: begin
          if (r_count == 6'(MUL_LAT)) begin
            r_hi    <= w_stage[MUL_LAT-1][63:32];
            r_lo    <= w_stage[MUL_LAT-1][31:0];
            r_state <= S_DONE;
            r_count <= '0;
          end else begin
            r_count <= r_count + 6'd1;
          end
        end
        S_DIV: begin
          r_a   <= w_q_next;
          r_rem <= w_rem_next;
          if (r_count == 6'd32) begin
            // Sign fix-up; the 0x8000_0000 / -1 overflow wraps naturally.
            r_lo    <= r_neg_q ? -w_q_next : w_q_next;
            r_hi    <= r_neg_r ? -w_rem_next : w_rem_next;
            r_state <= S_DONE;
            r_count <= '0;
          end else begin
            r_count <= r_count + 6'd1;
          end
        end
        S_DONE: begin
          if (!bus.stall_ex) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ---- outputs ----
  // Stall covers the accept cycle too, so EX holds before the operands change.
  assign bus.stallreq    = ~rst & ~bus.annul &
                           (((r_state == S_IDLE) & w_trigger) |
                            (r_state == S_MUL) | (r_state == S_DIV));
  assign bus.hilo_we     = ~rst & ~bus.annul & (r_state == S_DONE);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.hi_wdata    = r_hi;
  assign bus.lo_wdata    = r_lo;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_muldiv_sched.sv
// ---------------------------------------------------------------------------
// tb_muldiv_sched
// Directed bench for muldiv_sched (MUL_LAT=2). The driver issues operations
// and pushes hand-computed HI/LO results into a queue; an independent monitor
// pops and compares on every fresh HI/LO write and re-checks held writes.
// ---------------------------------------------------------------------------
module tb_muldiv_sched;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  exp_t sb_q[$];

  muldiv_sched_if bus ();

  muldiv_sched #(.MUL_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- monitor / scoreboard ----
  exp_t mon_cur;
  bit   mon_holding;

  always @(negedge clk) begin
    if (rst) begin
      mon_holding = 1'b0;
    end else if (bus.hilo_we) begin
      if (!mon_holding) begin
        check("write_expected", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) mon_cur = sb_q.pop_front();
      end
      check("hi_wdata", 64'(bus.hi_wdata), 64'(mon_cur.hi));
      check("lo_wdata", 64'(bus.lo_wdata), 64'(mon_cur.lo));
      check("div_by_zero", 64'(bus.div_by_zero), 64'(mon_cur.dbz));
      mon_holding = bus.stall_ex;
    end else begin
      mon_holding = 1'b0;
    end
  end

  // ---- driver ----
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                        input int estall, input int hold);
    exp_t e;
    int   cnt;
    int   we_cnt;
    @(posedge clk); #1;
    bus.op_valid = 1'b1;
    bus.op_code  = op;
    bus.src_a    = a;
    bus.src_b    = b;
    bus.stall_ex = (hold > 0);
    e.hi = ehi; e.lo = elo; e.dbz = edbz;
    sb_q.push_back(e);
    @(negedge clk);
    cnt = bus.stallreq ? 1 : 0;
    // Operands are free to change once accepted.
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    bus.op_code  = 3'($urandom);
    bus.src_a    = $urandom;
    bus.src_b    = $urandom;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.stallreq) break;
      cnt++;
    end
    check("stall_cycles", 64'(cnt), 64'(estall));
    we_cnt = bus.hilo_we ? 1 : 0;
    for (int j = 1; j <= hold; j++) begin
      @(posedge clk); #1;
      if (j == hold) bus.stall_ex = 1'b0;
      @(negedge clk);
      if (bus.hilo_we) we_cnt++;
    end
    check("we_cycles", 64'(we_cnt), 64'(hold + 1));
    @(negedge clk);
    check("idle_hilo_we", 64'(bus.hilo_we), 64'd0);
    check("idle_busy", 64'(bus.busy), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stallreq"}, 64'(bus.stallreq), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_hilo_we"}, 64'(bus.hilo_we), 64'd0);
    check({tag, "_hi"}, 64'(bus.hi_wdata), 64'd0);
    check({tag, "_lo"}, 64'(bus.lo_wdata), 64'd0);
    check({tag, "_dbz"}, 64'(bus.div_by_zero), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.op_valid = 1'b0;
    bus.op_code  = 3'd0;
    bus.src_a    = '0;
    bus.src_b    = '0;
    bus.stall_ex = 1'b0;
    bus.annul    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: unsigned full-scale multiply
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 3, 0);
    // 2: signed multiply and signed divide
    run_op(OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 3, 0);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 0);
    run_op(OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 33, 0);
    run_op(OP_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 3, 0);
    run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 3, 0);
    run_op(OP_DIVU,  32'd1000000,   32'd7,         32'h0000_0001, 32'h0002_2E09, 1'b0, 33, 0);
    run_op(OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 33, 0);
    // 3: divide by zero and signed overflow
    run_op(OP_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1, 0);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33, 0);

    // illegal op code is never accepted
    @(posedge clk); #1;
    bus.op_valid = 1'b1;
    bus.op_code  = 3'd5;
    @(negedge clk);
    check("illegal_stallreq", 64'(bus.stallreq), 64'd0);
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    @(negedge clk);
    check("illegal_busy", 64'(bus.busy), 64'd0);

    // 4: annul in cycle 10 of a divide, then annul blocking an IDLE issue
    @(posedge clk); #1;
    bus.op_valid = 1'b1;
    bus.op_code  = OP_DIV;
    bus.src_a    = 32'd1000;
    bus.src_b    = 32'd3;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.annul = 1'b1;
    @(negedge clk);
    check("annul_stallreq", 64'(bus.stallreq), 64'd0);
    check("annul_hilo_we", 64'(bus.hilo_we), 64'd0);
    check("annul_busy_before", 64'(bus.busy), 64'd1);
    @(posedge clk); #1;
    bus.annul = 1'b0;
    @(negedge clk);
    check("annul_busy_after", 64'(bus.busy), 64'd0);
    check("annul_stall_after", 64'(bus.stallreq), 64'd0);
    @(posedge clk); #1;
    bus.op_valid = 1'b1;
    bus.op_code  = OP_MULT;
    bus.annul    = 1'b1;
    @(negedge clk);
    check("annul_idle_stallreq", 64'(bus.stallreq), 64'd0);
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    bus.annul    = 1'b0;
    @(negedge clk);
    check("annul_idle_busy", 64'(bus.busy), 64'd0);
    run_op(OP_DIVU, 32'd9, 32'd4, 32'h0000_0001, 32'h0000_0002, 1'b0, 33, 0);

    // 5: downstream stall holds the write for two extra cycles
    run_op(OP_MULTU, 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F, 1'b0, 3, 2);

    // 6: reset in the middle of a divide, then a multiply straight after
    @(posedge clk); #1;
    bus.op_valid = 1'b1;
    bus.op_code  = OP_DIVU;
    bus.src_a    = 32'd500;
    bus.src_b    = 32'd7;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0, 3, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
